rpn_stack_core: RTL and testbench



---
 rtl/rpn_pkg.sv | 31 +++
 rtl/reg_load_enable.sv | 18 +
 rtl/rpn_alu.sv | 31 +++
 rtl/rpn_stack_core.sv | 154 +++++++++++++++
 tb/tb_rpn_stack_core.sv | 220 ++++++++++++++++++++++
 5 files changed

// File: rtl/rpn_pkg.sv
// Shared opcodes, FSM encodings and opcode classification for the RPN core.
// Define RPN_MUL_EN to make opcode 4'hA a binary multiply.
package rpn_pkg;

  localparam logic [3:0] OP_NOP   = 4'h0;
  localparam logic [3:0] OP_PUSH  = 4'h1;
  localparam logic [3:0] OP_POP   = 4'h2;
  localparam logic [3:0] OP_ADD   = 4'h3;
  localparam logic [3:0] OP_SUB   = 4'h4;
  localparam logic [3:0] OP_AND   = 4'h5;
  localparam logic [3:0] OP_OR    = 4'h6;
  localparam logic [3:0] OP_DUP   = 4'h7;
  localparam logic [3:0] OP_SWAP  = 4'h8;
  localparam logic [3:0] OP_CLEAR = 4'h9;
  localparam logic [3:0] OP_MUL   = 4'hA;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_WB   = 2'd2;

  function automatic logic is_binary(input logic [3:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR: return 1'b1;
`ifdef RPN_MUL_EN
      OP_MUL: return 1'b1;
`endif
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/reg_load_enable.sv
// Load-enable register, async active-high clear. Latency 1 cycle.
// No backpressure: captures d on any edge where en is high.
module reg_load_enable #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)     q <= '0;
    else if (en) q <= d;
  end

endmodule

// File: rtl/rpn_alu.sv
// Combinational RPN ALU, result = a op b (a is NOS); zero latency.
// No handshake; MUL exists only when RPN_MUL_EN is defined.
module rpn_alu import rpn_pkg::*; #(
  parameter int WIDTH = 8
) (
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result
);

`ifdef RPN_MUL_EN
  logic [2*WIDTH-1:0] prod;
  assign prod = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
`endif

  always_comb begin
    result = '0;
    case (op)
      OP_ADD: result = a + b;
      OP_SUB: result = a - b;
      OP_AND: result = a & b;
      OP_OR:  result = a | b;
`ifdef RPN_MUL_EN
      OP_MUL: result = prod[WIDTH-1:0];
`endif
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/rpn_stack_core.sv
// RPN operand stack + ALU; done 1 cycle after accept (2 for binary ops), RPN_MUL_EN adds MUL.
// cmd_ready only in S_IDLE; cmd_valid while busy is ignored, source must hold it.
module rpn_stack_core import rpn_pkg::*; #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                       CLOCK_50,
  input  logic                       reset,
  input  logic                       cmd_valid,
  output logic                       cmd_ready,
  input  logic [3:0]                 cmd_op,
  input  logic [WIDTH-1:0]           cmd_data,
  output logic                       done,
  output logic [WIDTH-1:0]           top,
  output logic [$clog2(DEPTH+1)-1:0] depth,
  output logic                       err_ovf,
  output logic                       err_unf
);

  localparam int DW = $clog2(DEPTH + 1);
  localparam int IW = $clog2(DEPTH);
  localparam logic [DW-1:0] FULL = DW'(DEPTH);

  logic [1:0]         state, state_nxt;
  logic               accept;
  logic [WIDTH+3:0]   cmd_q;
  logic [3:0]         op_q;
  logic [WIDTH-1:0]   data_q;
  logic [WIDTH-1:0]   stk [DEPTH];
  logic [IW-1:0]      idx_top, idx_nos, idx_push;
  logic [WIDTH-1:0]   tos, nos, alu_res, res_q;
  logic [DW-1:0]      depth_nxt;
  logic               ovf_nxt, unf_nxt, wr_en, swap_en;
  logic [IW-1:0]      wr_idx;
  logic [WIDTH-1:0]   wr_dat;

  assign cmd_ready = (state == S_IDLE);
  assign done      = (state == S_WB);
  assign accept    = cmd_valid && cmd_ready;

  reg_load_enable #(.WIDTH(WIDTH + 4)) u_cmd_reg (
    .clk (CLOCK_50),
    .rst (reset),
    .en  (accept),
    .d   ({cmd_op, cmd_data}),
    .q   (cmd_q)
  );
  assign op_q   = cmd_q[WIDTH+3:WIDTH];
  assign data_q = cmd_q[WIDTH-1:0];

  assign idx_top  = IW'(depth - DW'(1));
  assign idx_nos  = IW'(depth - DW'(2));
  assign idx_push = IW'(depth);
  assign tos      = stk[idx_top];
  assign nos      = stk[idx_nos];
  assign top      = (depth == '0) ? '0 : tos;

  rpn_alu #(.WIDTH(WIDTH)) u_alu (
    .op     (op_q),
    .a      (nos),
    .b      (tos),
    .result (alu_res)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (accept) state_nxt = is_binary(cmd_op) ? S_EXEC : S_WB;
      S_EXEC:  state_nxt = S_WB;
      S_WB:    state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Writeback decode: every error path leaves contents and depth untouched.
  always_comb begin
    depth_nxt = depth;
    ovf_nxt   = err_ovf;
    unf_nxt   = err_unf;
    wr_en     = 1'b0;
    swap_en   = 1'b0;
    wr_idx    = idx_push;
    wr_dat    = data_q;
    if (state == S_WB) begin
      if (is_binary(op_q)) begin
        if (depth < DW'(2)) unf_nxt = 1'b1;
        else begin
          wr_en     = 1'b1;
          wr_idx    = idx_nos;
          wr_dat    = res_q;
          depth_nxt = depth - DW'(1);
        end
      end else begin
        case (op_q)
          OP_PUSH: begin
            if (depth == FULL) ovf_nxt = 1'b1;
            else begin
              wr_en     = 1'b1;
              depth_nxt = depth + DW'(1);
            end
          end
          OP_POP: begin
            if (depth == '0) unf_nxt = 1'b1;
            else depth_nxt = depth - DW'(1);
          end
          OP_DUP: begin
            if (depth == FULL) ovf_nxt = 1'b1;
            else if (depth == '0) unf_nxt = 1'b1;
            else begin
              wr_en     = 1'b1;
              wr_dat    = tos;
              depth_nxt = depth + DW'(1);
            end
          end
          OP_SWAP: begin
            if (depth < DW'(2)) unf_nxt = 1'b1;
            else swap_en = 1'b1;
          end
          OP_CLEAR: begin
            depth_nxt = '0;
            ovf_nxt   = 1'b0;
            unf_nxt   = 1'b0;
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state   <= S_IDLE;
      depth   <= '0;
      err_ovf <= 1'b0;
      err_unf <= 1'b0;
    end else begin
      state   <= state_nxt;
      depth   <= depth_nxt;
      err_ovf <= ovf_nxt;
      err_unf <= unf_nxt;
    end
  end

  // Storage and ALU result carry no reset; depth alone defines validity.
  always_ff @(posedge CLOCK_50) begin
    if (state == S_EXEC) res_q <= alu_res;
    if (wr_en) stk[wr_idx] <= wr_dat;
    if (swap_en) begin
      stk[idx_top] <= nos;
      stk[idx_nos] <= tos;
    end
  end

endmodule

// File: tb/tb_rpn_stack_core.sv
// Bench for rpn_stack_core (WIDTH=8, DEPTH=4): vector table with scoreboard plus handshake/reset sequences.
module tb_rpn_stack_core;
  import rpn_pkg::*;

  localparam int W = 8;
  localparam int D = 4;

  logic         CLOCK_50 = 1'b0;
  logic         reset;
  logic         cmd_valid;
  logic         cmd_ready;
  logic [3:0]   cmd_op;
  logic [W-1:0] cmd_data;
  logic         done;
  logic [W-1:0] top;
  logic [2:0]   depth;
  logic         err_ovf;
  logic         err_unf;

  always #10 CLOCK_50 = ~CLOCK_50;

  rpn_stack_core #(.WIDTH(W), .DEPTH(D)) dut (
    .CLOCK_50  (CLOCK_50),
    .reset     (reset),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_data  (cmd_data),
    .done      (done),
    .top       (top),
    .depth     (depth),
    .err_ovf   (err_ovf),
    .err_unf   (err_unf)
  );

  typedef struct {
    logic [3:0] op;
    logic [7:0] data;
    int         lat;
    logic [7:0] top;
    int         dep;
    logic       ovf;
    logic       unf;
  } vec_t;

  typedef struct {
    int         lat;
    logic [7:0] top;
    int         dep;
    logic       ovf;
    logic       unf;
  } exp_t;

  vec_t vt[$];
  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input logic [3:0] op, input logic [7:0] data, input int lat,
                     input logic [7:0] t, input int dep, input logic ovf, input logic unf);
    vec_t v;
    v.op = op; v.data = data; v.lat = lat; v.top = t; v.dep = dep; v.ovf = ovf; v.unf = unf;
    vt.push_back(v);
  endtask

  // Entered and left on a negedge with the core idle.
  task automatic run_cmd(input vec_t v, input int idx);
    exp_t e;
    exp_t g;
    int   lat;
    e.lat = v.lat; e.top = v.top; e.dep = v.dep; e.ovf = v.ovf; e.unf = v.unf;
    sb.push_back(e);
    check($sformatf("v%0d ready", idx), {31'd0, cmd_ready}, 32'd1);
    cmd_valid = 1'b1;
    cmd_op    = v.op;
    cmd_data  = v.data;
    @(posedge CLOCK_50);
    @(negedge CLOCK_50);
    cmd_valid = 1'b0;
    lat = 1;
    while (!done && lat < 10) begin
      @(negedge CLOCK_50);
      lat++;
    end
    g = sb.pop_front();
    if (!done) check($sformatf("v%0d done timeout", idx), 32'd0, 32'd1);
    check($sformatf("v%0d latency", idx), lat, g.lat);
    @(negedge CLOCK_50);
    check($sformatf("v%0d done cleared", idx), {31'd0, done}, 32'd0);
    check($sformatf("v%0d top", idx), {24'd0, top}, {24'd0, g.top});
    check($sformatf("v%0d depth", idx), {29'd0, depth}, g.dep);
    check($sformatf("v%0d err_ovf", idx), {31'd0, err_ovf}, {31'd0, g.ovf});
    check($sformatf("v%0d err_unf", idx), {31'd0, err_unf}, {31'd0, g.unf});
  endtask

  initial begin
    int   dones;
    vec_t v;

    reset = 1'b1; cmd_valid = 1'b0; cmd_op = OP_NOP; cmd_data = '0;
    repeat (2) @(negedge CLOCK_50);
    check("reset ready", {31'd0, cmd_ready}, 32'd1);
    check("reset done", {31'd0, done}, 32'd0);
    reset = 1'b0;
    @(negedge CLOCK_50);
    check("post-reset depth", {29'd0, depth}, 32'd0);
    check("post-reset top", {24'd0, top}, 32'd0);
    check("post-reset flags", {30'd0, err_ovf, err_unf}, 32'd0);

    add(OP_PUSH, 8'h05, 1, 8'h05, 1, 0, 0);
    add(OP_PUSH, 8'h03, 1, 8'h03, 2, 0, 0);
    add(OP_SUB,  8'h00, 2, 8'h02, 1, 0, 0);
    add(OP_POP,  8'h00, 1, 8'h00, 0, 0, 0);
    add(OP_PUSH, 8'hF0, 1, 8'hF0, 1, 0, 0);
    add(OP_PUSH, 8'h20, 1, 8'h20, 2, 0, 0);
    add(OP_ADD,  8'h00, 2, 8'h10, 1, 0, 0);
    add(OP_PUSH, 8'h10, 1, 8'h10, 2, 0, 0);
    add(OP_PUSH, 8'h11, 1, 8'h11, 3, 0, 0);
`ifdef RPN_MUL_EN
    add(OP_MUL,  8'h00, 2, 8'h10, 2, 0, 0);
`else
    add(OP_MUL,  8'h00, 1, 8'h11, 3, 0, 0);
`endif
    add(OP_CLEAR, 8'h00, 1, 8'h00, 0, 0, 0);
    add(OP_PUSH, 8'h0A, 1, 8'h0A, 1, 0, 0);
    add(OP_PUSH, 8'h0B, 1, 8'h0B, 2, 0, 0);
    add(OP_PUSH, 8'h0C, 1, 8'h0C, 3, 0, 0);
    add(OP_PUSH, 8'h0D, 1, 8'h0D, 4, 0, 0);
    add(OP_PUSH, 8'h0E, 1, 8'h0D, 4, 1, 0);
    add(OP_DUP,  8'h00, 1, 8'h0D, 4, 1, 0);
    add(OP_CLEAR, 8'h00, 1, 8'h00, 0, 0, 0);
    add(OP_POP,  8'h00, 1, 8'h00, 0, 0, 1);
    add(OP_DUP,  8'h00, 1, 8'h00, 0, 0, 1);
    add(OP_PUSH, 8'h07, 1, 8'h07, 1, 0, 1);
    add(OP_ADD,  8'h00, 2, 8'h07, 1, 0, 1);
    add(OP_CLEAR, 8'h00, 1, 8'h00, 0, 0, 0);
    add(OP_PUSH, 8'h01, 1, 8'h01, 1, 0, 0);
    add(OP_PUSH, 8'h02, 1, 8'h02, 2, 0, 0);
    add(OP_SWAP, 8'h00, 1, 8'h01, 2, 0, 0);
    add(OP_DUP,  8'h00, 1, 8'h01, 3, 0, 0);
    add(OP_POP,  8'h00, 1, 8'h01, 2, 0, 0);
    add(OP_OR,   8'h00, 2, 8'h03, 1, 0, 0);
    add(OP_PUSH, 8'h06, 1, 8'h06, 2, 0, 0);
    add(OP_AND,  8'h00, 2, 8'h02, 1, 0, 0);
    add(OP_NOP,  8'h55, 1, 8'h02, 1, 0, 0);
    add(4'hF,    8'h55, 1, 8'h02, 1, 0, 0);
    add(OP_SWAP, 8'h00, 1, 8'h02, 1, 0, 1);
    add(OP_CLEAR, 8'h00, 1, 8'h00, 0, 0, 0);
    add(OP_PUSH, 8'h03, 1, 8'h03, 1, 0, 0);
    add(OP_PUSH, 8'h05, 1, 8'h05, 2, 0, 0);
    add(OP_SUB,  8'h00, 2, 8'hFE, 1, 0, 0);
    add(OP_CLEAR, 8'h00, 1, 8'h00, 0, 0, 0);

    for (int i = 0; i < vt.size(); i++) begin
      v = vt[i];
      run_cmd(v, i);
    end

    // PUSH held valid for six edges: only the idle edges accept.
    dones = 0;
    cmd_valid = 1'b1; cmd_op = OP_PUSH; cmd_data = 8'h33;
    repeat (6) begin
      @(posedge CLOCK_50);
      @(negedge CLOCK_50);
      if (done) dones++;
    end
    cmd_valid = 1'b0;
    check("held valid done count", dones, 32'd3);
    check("held valid depth", {29'd0, depth}, 32'd3);
    check("held valid top", {24'd0, top}, 32'h33);

    v.op = OP_CLEAR; v.data = 0; v.lat = 1; v.top = 0; v.dep = 0; v.ovf = 0; v.unf = 0;
    run_cmd(v, 100);
    v.op = OP_PUSH; v.data = 8'h01; v.top = 8'h01; v.dep = 1;
    run_cmd(v, 101);
    v.data = 8'h02; v.top = 8'h02; v.dep = 2;
    run_cmd(v, 102);

    // Reset while an ADD sits in S_EXEC.
    cmd_valid = 1'b1; cmd_op = OP_ADD; cmd_data = '0;
    @(posedge CLOCK_50);
    @(negedge CLOCK_50);
    cmd_valid = 1'b0;
    check("exec ready low", {31'd0, cmd_ready}, 32'd0);
    reset = 1'b1;
    #1;
    check("abort ready", {31'd0, cmd_ready}, 32'd1);
    check("abort depth", {29'd0, depth}, 32'd0);
    check("abort top", {24'd0, top}, 32'd0);
    check("abort done", {31'd0, done}, 32'd0);
    dones = 0;
    repeat (2) begin
      @(negedge CLOCK_50);
      if (done) dones++;
    end
    reset = 1'b0;
    repeat (3) begin
      @(negedge CLOCK_50);
      if (done) dones++;
    end
    check("abort no done", dones, 32'd0);
    check("abort depth after", {29'd0, depth}, 32'd0);

    v.data = 8'h09; v.top = 8'h09; v.dep = 1;
    run_cmd(v, 103);
    check("scoreboard drained", sb.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
